// File: rtl/reset_btn_ctrl_pkg.sv
// Shared definitions for reset and button conditioning: FSM encodings and
// clock-derived timing defaults.
package reset_btn_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STRETCH = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2
  } rst_state_t;

  localparam int PIXEL_CLOCK_HZ = 12_500_000;
  // 5 ms debounce window at the pixel clock
  localparam int DB_CYCLES_DEF  = PIXEL_CLOCK_HZ / 200;
  localparam int POR_CYCLES_DEF = 8;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_btn_ctrl_btn_debounce.sv
// One button channel: 2-flop sync, polarity fix, DB_CYCLES qualification, strobes.
// Latency 2 + DB_CYCLES edges from pin change to level/strobe; no backpressure.
module btn_debounce
  import reset_btn_ctrl_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic btn,
  output logic level,
  output logic level_nxt,
  output logic press_stb,
  output logic release_stb
);

  localparam int            CW      = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          s;
  logic          qualified;
  logic [CW-1:0] cnt;

  // Synchroniser resets to the unpressed pin level so release of reset
  // never looks like an edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  assign s         = sync2 ^ ACTIVE_LOW;
  assign qualified = (s != level) && (cnt == CNT_MAX);
  // Exposed so the reset FSM can react on the same edge the level changes
  assign level_nxt = qualified ? s : level;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      level       <= 1'b0;
      cnt         <= '0;
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
    end else begin
      level       <= level_nxt;
      press_stb   <= qualified & s;
      release_stb <= qualified & ~s;
      if ((s == level) || qualified) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_btn_ctrl.sv
// Debounces NUM_BTN buttons and sequences a stretched core reset from reset_n and a reset button.
// Core reset rises POR_CYCLES edges after reset_n release or reset-button release; no backpressure.
module reset_btn_ctrl
  import reset_btn_ctrl_pkg::*;
#(
  parameter int                 NUM_BTN        = 7,
  parameter logic [NUM_BTN-1:0] BTN_ACTIVE_LOW = 7'b0000001,
  parameter int                 DB_CYCLES      = DB_CYCLES_DEF,
  parameter int                 POR_CYCLES     = POR_CYCLES_DEF,
  parameter int                 RESET_BTN      = 0
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               core_reset_n,
  output logic               por_done
);

  localparam int            PW      = cnt_width(POR_CYCLES);
  localparam logic [PW-1:0] POR_MAX = PW'(POR_CYCLES - 1);

  logic [NUM_BTN-1:0] lvl_nxt;
  logic               rst_btn_nxt;
  logic               unused_lvl_nxt;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES  (DB_CYCLES),
      .ACTIVE_LOW (BTN_ACTIVE_LOW[i])
    ) u_debounce (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .btn         (btn[i]),
      .level       (btn_level[i]),
      .level_nxt   (lvl_nxt[i]),
      .press_stb   (btn_press[i]),
      .release_stb (btn_release[i])
    );
  end

  // Only the reset button's look-ahead level feeds the FSM
  assign rst_btn_nxt    = lvl_nxt[RESET_BTN];
  assign unused_lvl_nxt = ^lvl_nxt;

  rst_state_t    state;
  rst_state_t    state_nxt;
  logic [PW-1:0] st_cnt;
  logic [PW-1:0] st_cnt_nxt;
  logic          por_nxt;

  always_comb begin
    state_nxt  = state;
    st_cnt_nxt = '0;
    por_nxt    = por_done;
    case (state)
      ST_STRETCH: begin
        if (st_cnt == POR_MAX) begin
          state_nxt = ST_RUN;
          por_nxt   = 1'b1;
        end else begin
          st_cnt_nxt = st_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (rst_btn_nxt) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!rst_btn_nxt) state_nxt = ST_STRETCH;
      end
      default: state_nxt = ST_STRETCH;
    endcase
  end

  // core_reset_n is registered from the next state so it moves on the
  // same edge as the transition, with no decode glitch.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_STRETCH;
      st_cnt       <= '0;
      por_done     <= 1'b0;
      core_reset_n <= 1'b0;
    end else begin
      state        <= state_nxt;
      st_cnt       <= st_cnt_nxt;
      por_done     <= por_nxt;
      core_reset_n <= (state_nxt == ST_RUN);
    end
  end

endmodule

// File: tb/tb_reset_btn_ctrl.sv
// Directed and random stimulus for reset_btn_ctrl, checked every cycle
// against a sample-history reference model.
module tb_reset_btn_ctrl;

  localparam int         NB   = 3;
  localparam int         DB   = 4;
  localparam int         POR  = 8;
  localparam logic [2:0] MASK = 3'b001;
  localparam logic [2:0] IDLE = 3'b001;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic [NB-1:0] btn;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          core_reset_n;
  logic          por_done;

  always #5 clk_sys = ~clk_sys;

  reset_btn_ctrl #(
    .NUM_BTN        (NB),
    .BTN_ACTIVE_LOW (MASK),
    .DB_CYCLES      (DB),
    .POR_CYCLES     (POR),
    .RESET_BTN      (0)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .btn          (btn),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .core_reset_n (core_reset_n),
    .por_done     (por_done)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: raw pin samples per edge, per-button history of
  // synchronised samples, and a simple reset sequencer.
  logic [2:0] rq[$];
  bit         sh[NB][$];
  logic [2:0] m_lvl, m_press, m_rel;
  logic       m_core, m_por;
  bit         stretching, holding;
  int         st_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("btn_level",    32'(btn_level),    32'(m_lvl));
    check("btn_press",    32'(btn_press),    32'(m_press));
    check("btn_release",  32'(btn_release),  32'(m_rel));
    check("core_reset_n", 32'(core_reset_n), 32'(m_core));
    check("por_done",     32'(por_done),     32'(m_por));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"},   32'(btn_level),    32'd0);
    check({tag, "_press"},   32'(btn_press),    32'd0);
    check({tag, "_release"}, 32'(btn_release),  32'd0);
    check({tag, "_core"},    32'(core_reset_n), 32'd0);
    check({tag, "_por"},     32'(por_done),     32'd0);
  endtask

  task automatic model_reset();
    m_lvl = '0; m_press = '0; m_rel = '0;
    m_core = 1'b0; m_por = 1'b0;
    stretching = 1'b1; holding = 1'b0; st_cnt = 0;
    rq.delete();
    rq.push_back(IDLE);
    rq.push_back(IDLE);
    for (int b = 0; b < NB; b++) sh[b].delete();
  endtask

  task automatic model_edge();
    logic [2:0] s, nl;
    bit all_diff;
    // Value seen by the debouncer = pin sampled two edges earlier
    s = rq[0] ^ MASK;
    void'(rq.pop_front());
    rq.push_back(btn);
    nl = m_lvl;
    for (int b = 0; b < NB; b++) begin
      sh[b].push_back(s[b]);
      if (sh[b].size() > DB) void'(sh[b].pop_front());
      if (sh[b].size() == DB) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) if (sh[b][j] == m_lvl[b]) all_diff = 1'b0;
        if (all_diff) nl[b] = ~m_lvl[b];
      end
    end
    m_press = nl & ~m_lvl;
    m_rel   = ~nl & m_lvl;
    m_lvl   = nl;
    if (stretching) begin
      st_cnt++;
      if (st_cnt == POR) begin
        stretching = 1'b0; m_por = 1'b1; m_core = 1'b1;
      end
    end else if (holding) begin
      if (!m_lvl[0]) begin
        holding = 1'b0; stretching = 1'b1; st_cnt = 0;
      end
    end else if (m_lvl[0]) begin
      holding = 1'b1; m_core = 1'b0;
    end
  endtask

  task automatic step(input logic [2:0] b, input logic rn);
    @(negedge clk_sys);
    btn = b;
    reset_n = rn;
    if (!rn) model_reset();
    @(posedge clk_sys);
    if (rn) model_edge();
    else model_reset();
    #1 check_all();
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1 check_zero(tag);
    model_reset();
    btn = IDLE;
    repeat (3) step(IDLE, 1'b0);
  endtask

  initial begin
    int   t_a, t_b;
    logic acc;
    logic [2:0] rb;
    logic       rrn;
    int         hold;

    reset_n = 1'b0;
    btn     = IDLE;
    model_reset();
    #3 check_zero("reset");
    repeat (3) step(IDLE, 1'b0);

    // Power-on stretch
    t_a = -1; acc = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(IDLE, 1'b1);
      if (core_reset_n && t_a < 0) t_a = i;
      acc |= |btn_press | |btn_release;
    end
    check("por_rise_edge", 32'(t_a), 32'd8);
    check("por_strobes", 32'(acc), 32'd0);

    // Clean press and release of btn[1]
    t_a = -1;
    for (int i = 1; i <= 10; i++) begin
      step(3'b011, 1'b1);
      if (btn_level[1] && t_a < 0) begin
        t_a = i;
        check("press1_strobe", 32'(btn_press[1]), 32'd1);
      end
    end
    check("press1_latency", 32'(t_a), 32'd6);
    t_a = -1;
    for (int i = 1; i <= 10; i++) begin
      step(IDLE, 1'b1);
      if (!btn_level[1] && t_a < 0) begin
        t_a = i;
        check("release1_strobe", 32'(btn_release[1]), 32'd1);
      end
    end
    check("release1_latency", 32'(t_a), 32'd6);

    // Bounce on btn[2]: 3 high / 1 low never qualifies
    acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(((i % 4) != 3) ? 3'b101 : IDLE, 1'b1);
      acc |= btn_level[2] | btn_press[2] | btn_release[2];
    end
    check("bounce_quiet", 32'(acc), 32'd0);
    repeat (6) step(IDLE, 1'b1);

    // Reset button held 20 cycles then released
    t_a = -1; acc = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(3'b000, 1'b1);
      if (!core_reset_n && t_a < 0) t_a = i;
      if (t_a > 0 && core_reset_n) acc = 1'b1;
      if (!por_done) acc = 1'b1;
    end
    check("rstbtn_fall_edge", 32'(t_a), 32'd6);
    t_b = -1;
    for (int i = 1; i <= 20; i++) begin
      step(IDLE, 1'b1);
      if (core_reset_n && t_b < 0) t_b = i;
      if (!por_done) acc = 1'b1;
    end
    check("rstbtn_rise_edge", 32'(t_b), 32'd14);
    check("rstbtn_hold_por", 32'(acc), 32'd0);

    // Async reset mid-debounce
    step(3'b011, 1'b1);
    step(3'b011, 1'b1);
    step(3'b011, 1'b1);
    async_reset("mid_db");
    t_a = -1; acc = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(IDLE, 1'b1);
      if (core_reset_n && t_a < 0) t_a = i;
      acc |= |btn_press | |btn_release;
    end
    check("mid_db_rise", 32'(t_a), 32'd8);
    check("mid_db_stale", 32'(acc), 32'd0);

    // Async reset mid-HOLD
    repeat (8) step(3'b000, 1'b1);
    check("in_hold", 32'(core_reset_n), 32'd0);
    async_reset("mid_hold");
    t_a = -1; acc = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(IDLE, 1'b1);
      if (core_reset_n && t_a < 0) t_a = i;
      acc |= |btn_press | |btn_release;
    end
    check("mid_hold_rise", 32'(t_a), 32'd8);
    check("mid_hold_stale", 32'(acc), 32'd0);

    // Simultaneous press of btn[1] and btn[2]
    t_a = -1; t_b = -1; acc = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(3'b111, 1'b1);
      if (btn_press[1] && t_a < 0) t_a = i;
      if (btn_press[2] && t_b < 0) t_b = i;
      if (!core_reset_n) acc = 1'b1;
    end
    check("simul_press1", 32'(t_a), 32'd6);
    check("simul_press2", 32'(t_b), 32'd6);
    check("simul_core", 32'(acc), 32'd0);
    repeat (8) step(IDLE, 1'b1);

    // Random phase against the model
    for (int n = 0; n < 120; n++) begin
      rb   = 3'($urandom);
      rrn  = ($urandom_range(0, 29) != 0);
      hold = $urandom_range(1, 9);
      for (int k = 0; k < hold; k++) step(rb, rrn);
    end
    repeat (20) step(IDLE, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reset_btn_ctrl.md
# reset_btn_ctrl

Parametrised reset and button conditioning for the ZX81 ULX3S top level. It replaces the fixed 8-clock power-on shift register and the raw `btn` wiring. The block synchronises and debounces N buttons, emits press and release strobes, and sequences a stretched, glitch-free core reset from power-on, PLL lock and a designated reset button. It sits between the board pins and `fpga_zx81` in the `clk_sys` domain.

## Interface
- `NUM_BTN`, 7: number of button inputs (≥1).
- `BTN_ACTIVE_LOW`, 7'b0000001: per-bit mask; a set bit means that button reads 0 when pressed.
- `DB_CYCLES`, 62500: debounce qualification length in `clk_sys` cycles (≥2); 5 ms at 12.5 MHz.
- `POR_CYCLES`, 8: reset stretch length in cycles (≥1).
- `RESET_BTN`, 0: index of the button that forces core reset.

Ports:
- `clk_sys`  in  1  system clock, the only clock.
- `reset_n`  in  1  reset, asynchronous, active-low (PLL lock / board reset).
- `btn`  in  NUM_BTN  raw asynchronous button pins.
- `btn_level`  out  NUM_BTN  debounced state, 1 = pressed, after polarity correction.
- `btn_press`  out  NUM_BTN  one-cycle strobe on a debounced 0→1 transition.
- `btn_release`  out  NUM_BTN  one-cycle strobe on a debounced 1→0 transition.
- `core_reset_n`  out  1  registered active-low reset for the core.
- `por_done`  out  1  goes high once the first stretch completes and stays high until `reset_n`.

## Operation
- **Reset values while `reset_n` = 0:** all outputs 0. The synchroniser flops load the idle (unpressed) level, debounce counters load 0, and the FSM enters STRETCH with the stretch counter at 0.
- **Per-button path:**
  - Two-flop synchroniser, then XOR with the `BTN_ACTIVE_LOW` bit to give `s`.
  - If `s` == `btn_level`, the counter clears.
  - Otherwise the counter increments. When the counter equals `DB_CYCLES-1` and the mismatch still holds, then on that edge:
    - `btn_level` takes `s`;
    - the counter clears;
    - `btn_press` or `btn_release` pulses for exactly one cycle.
  - Any single-cycle agreement restarts qualification.
  - Counter width is `$clog2(DB_CYCLES)`; it never wraps.
- **Reset FSM states:**
  - STRETCH: `core_reset_n` = 0; the counter counts up. At `POR_CYCLES-1` the FSM goes to RUN, the counter clears and `por_done` sets.
  - RUN: `core_reset_n` = 1. When `btn_level[RESET_BTN]` = 1 the FSM goes to HOLD.
  - HOLD: `core_reset_n` = 0 while the button is held. On `btn_level[RESET_BTN]` = 0 the FSM goes to STRETCH.
- **Button state in STRETCH:** the reset button is ignored; a press there takes effect only once RUN is reached.
- **Independence:** press and release strobes for all buttons, including `RESET_BTN`, are generated in every FSM state.
- **Simultaneous transitions:** multiple buttons may change on the same cycle; each channel is fully independent.
- **`reset_n` asserted mid-operation:** all state returns to the reset values immediately (asynchronous). On deassertion, a full STRETCH is always re-run.

## Timing
- Press-to-`btn_level` latency: 2 synchroniser cycles plus `DB_CYCLES` cycles of stable mismatch. The strobe is coincident with the `btn_level` change.
- `core_reset_n` rises exactly `POR_CYCLES` rising edges after the first edge with `reset_n` = 1, and again `POR_CYCLES` edges after HOLD exits.
- `core_reset_n` falls on the same edge `btn_level[RESET_BTN]` rises while in RUN; a 0-cycle RUN→HOLD→RUN glitch is impossible.
- All outputs are registered; no combinational path exists from `btn` to any output.

## Structure
- A shared header holds the FSM state encodings (STRETCH = 2'd0, RUN = 2'd1, HOLD = 2'd2) and the `DB_CYCLES` / `POR_CYCLES` defaults derived from `pixel_clock`.
- One sub-module, `btn_debounce`: synchroniser, polarity, counter and strobes for a single channel. It is generate-instanced `NUM_BTN` times.
- The FSM and stretch counter live in the top of this block.

## Test plan
Bench parameters: `NUM_BTN`=3, `BTN_ACTIVE_LOW`=3'b001, `DB_CYCLES`=4, `POR_CYCLES`=8, `RESET_BTN`=0.
1. **Power-on:** release `reset_n` with buttons idle → `core_reset_n` = 0 for 8 edges, then 1. `por_done` rises on the same edge. No strobes.
2. **Clean press:** drive `btn[1]` high and hold → `btn_level[1]` = 1 and `btn_press[1]` = 1 for one cycle, 6 edges after the input change. Releasing gives a symmetric `btn_release[1]`.
3. **Bounce:** toggle `btn[2]` with a 3-cycle-high / 1-cycle-low pattern for 40 cycles → `btn_level[2]` stays 0 and no strobes occur.
4. **Reset button:** in RUN, drive `btn[0]` low (pressed) for 20 cycles, then high:
   - `core_reset_n` falls 6 edges after the press and stays low throughout;
   - after the debounced release it stays low 8 more edges, then rises;
   - `por_done` stays 1.
5. **Async reset mid-stream:** assert `reset_n` mid-debounce and mid-HOLD → all outputs 0 immediately. After release, a full 8-cycle stretch runs and no stale strobe is emitted.
6. **Simultaneous press:** press `btn[1]` and `btn[2]` on the same cycle → both `btn_press` bits pulse on the same cycle; `core_reset_n` is unaffected.
